mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for a single-ported unified instruction/data memory shared by the fetch stage and the MEM-stage load/store unit of the pipelined core. It accepts at most one memory transaction per grant and tracks one outstanding read with a fixed latency. Read data is routed back to the owning requester. Round-robin on contention prevents fetch starvation, and a saturating counter records denied-request cycles for performance debug.

## Interface
- MEM_LAT, 1: memory read latency in cycles, legal range 1..4.
- CNT_W, 16: width of the contention counter.

- i_clk  in  1: clock, rising edge.
- i_reset  in  1: asynchronous, active-low reset.
- i_if_req  in  1: fetch read request, held until granted.
- i_if_addr  in  32: fetch byte address.
- i_if_flush  in  1: discard any outstanding fetch read (branch redirect).
- o_if_gnt  out  1: fetch request accepted this cycle.
- o_if_rvalid  out  1: fetch read data valid.
- o_if_rdata  out  32: fetch read data; 0 when o_if_rvalid=0.
- i_ls_req  in  1: LSU request, held until granted.
- i_ls_we  in  1: 1=store, 0=load.
- i_ls_addr  in  32: LSU byte address.
- i_ls_wdata  in  32: store data.
- i_ls_bmask  in  4: store byte enables.
- o_ls_gnt  out  1: LSU request accepted this cycle.
- o_ls_rvalid  out  1: load data valid.
- o_ls_rdata  out  32: load data; 0 when o_ls_rvalid=0.
- o_mem_req, o_mem_we  out  1 each: memory strobe and write enable.
- o_mem_addr, o_mem_wdata  out  32 each: memory address and write data.
- o_mem_bmask  out  4: memory byte enables; 4'b0000 on reads.
- i_mem_rdata  in  32: read data, valid MEM_LAT cycles after the read strobe.
- o_busy  out  1: a read is outstanding.
- o_conflict_cnt  out  CNT_W: saturating count of cycles with a denied request.

## Operation
- States: IDLE and WAIT. State registers: owner (IF/LS), last_gnt (IF/LS), lat_cnt (3 bits), drop flag.
- Grant is allowed when the state is IDLE, or when the state is WAIT and lat_cnt==1 (the rvalid cycle). This gives back-to-back issue.
- Arbitration when grant is allowed:
  - Only one requester active: that requester wins.
  - Both active: the requester not equal to last_gnt wins.
  - last_gnt resets to IF, so the LSU wins the first tie.
- The winner's gnt is asserted combinationally in the same cycle. o_mem_req=1, and o_mem_addr, o_mem_we, o_mem_wdata and o_mem_bmask are muxed from the winner. last_gnt is updated at the clock edge.
- Fetch is always a read (o_mem_we=0, o_mem_bmask=0).
- LSU store: completes in the grant cycle. No rvalid. State goes to or stays IDLE unless a read is also issued.
- Any read grant: next state is WAIT, lat_cnt=MEM_LAT, owner=winner, drop=0.
- In WAIT:
  - lat_cnt decrements each cycle.
  - At lat_cnt==1, the owner's rvalid=1 and its rdata=i_mem_rdata, except that a fetch owner with drop=1 gets no rvalid.
  - If no new read is granted that cycle, next state is IDLE.
- Flush: i_if_flush=1 while a fetch read is outstanding (including its rvalid cycle) sets drop, or suppresses rvalid in that same cycle. Flush has no effect on LSU transactions or on a fetch request that has not been granted.
- A request that is active but not granted in a cycle counts as one contention cycle. Both requests denied in one cycle also count as one. o_conflict_cnt increments by 1 and saturates at all-ones.
- o_busy = (state==WAIT).
- Addresses pass through unmodified; alignment is not checked.

## Timing
- Reset (asynchronous, i_reset=0):
  - State IDLE, last_gnt=IF, lat_cnt=0, drop=0, o_conflict_cnt=0.
  - All gnt, rvalid, o_mem_req, o_mem_we and o_busy are 0; all rdata, addr, wdata and bmask outputs are 0.
  - An outstanding read is abandoned; no rvalid follows reset release.
- Read granted in cycle t gives rvalid in cycle t+MEM_LAT.
- Sustained read throughput is one per MEM_LAT cycles. With MEM_LAT=1 this is one per cycle.
- With no requests, o_mem_req stays 0. Requesters hold address and data stable until gnt.

## Test plan
- Reset and single fetch: MEM_LAT=2, i_if_req=1 with addr 0x100 at t0.
  - Required: o_if_gnt=1 and o_mem_addr=0x100 at t0; o_if_rvalid=1 with mem data at t2; o_busy=1 during t1–t2.
- Tie after reset: both request at t0, store 0xDEADBEEF to 0x2000, bmask 4'b1111.
  - Required: LSU granted t0 with o_mem_we=1; fetch granted t1; o_conflict_cnt=1.
- Round-robin: both hold loads continuously with MEM_LAT=1.
  - Required: grants alternate LS, IF, LS, IF; each requester gets rvalid one cycle after its grant.
- Flush: fetch read granted t0 (MEM_LAT=3), i_if_flush=1 at t1.
  - Required: no o_if_rvalid at t3; new grant allowed at t3.
- Saturation: CNT_W=4, 20 denied cycles.
  - Required: o_conflict_cnt=0xF and holds.
- Reset mid-read: load granted, i_reset=0 before rvalid.
  - Required: all outputs 0 immediately; no rvalid after release.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, LSU and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int unsigned CNT_W = 16
);
  logic             i_if_req;
  logic [31:0]      i_if_addr;
  logic             i_if_flush;
  logic             o_if_gnt;
  logic             o_if_rvalid;
  logic [31:0]      o_if_rdata;
  logic             i_ls_req;
  logic             i_ls_we;
  logic [31:0]      i_ls_addr;
  logic [31:0]      i_ls_wdata;
  logic [3:0]       i_ls_bmask;
  logic             o_ls_gnt;
  logic             o_ls_rvalid;
  logic [31:0]      o_ls_rdata;
  logic             o_mem_req;
  logic             o_mem_we;
  logic [31:0]      o_mem_addr;
  logic [31:0]      o_mem_wdata;
  logic [3:0]       o_mem_bmask;
  logic [31:0]      i_mem_rdata;
  logic             o_busy;
  logic [CNT_W-1:0] o_conflict_cnt;

  modport slave (
    input  i_if_req, i_if_addr, i_if_flush, i_ls_req, i_ls_we, i_ls_addr,
           i_ls_wdata, i_ls_bmask, i_mem_rdata,
    output o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_rvalid, o_ls_rdata,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
           o_busy, o_conflict_cnt
  );

  modport master (
    output i_if_req, i_if_addr, i_if_flush, i_ls_req, i_ls_we, i_ls_addr,
           i_ls_wdata, i_ls_bmask, i_mem_rdata,
    input  o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_rvalid, o_ls_rdata,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
           o_busy, o_conflict_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the unified memory port shared by fetch and LSU,
// tracking one fixed-latency outstanding read and a saturating contention count.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_LS} req_t;

  state_t           state, state_nx;
  req_t             owner, owner_nx, last_gnt, last_gnt_nx;
  logic [2:0]       lat_cnt, lat_nx;
  logic             drop, drop_nx;
  logic [CNT_W-1:0] conflict_cnt;

  logic grant_ok, win_ls, win_if, rd_issue, rv_cycle, denied;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      last_gnt <= OWN_IF;
      lat_cnt  <= '0;
      drop     <= 1'b0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      last_gnt <= last_gnt_nx;
      lat_cnt  <= lat_nx;
      drop     <= drop_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    owner_nx        = owner;
    last_gnt_nx     = last_gnt;
    lat_nx          = lat_cnt;
    drop_nx         = drop;
    bus.o_if_gnt    = 1'b0;
    bus.o_ls_gnt    = 1'b0;
    bus.o_if_rvalid = 1'b0;
    bus.o_ls_rvalid = 1'b0;
    bus.o_if_rdata  = '0;
    bus.o_ls_rdata  = '0;
    bus.o_mem_req   = 1'b0;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    bus.o_mem_bmask = '0;

    // Grant is gated by reset so every combinational output drops to 0 at once.
    grant_ok = i_reset && ((state == IDLE) || (lat_cnt == 3'd1));
    win_ls   = grant_ok && bus.i_ls_req && (!bus.i_if_req || (last_gnt == OWN_IF));
    win_if   = grant_ok && bus.i_if_req && !win_ls;
    rd_issue = win_if || (win_ls && !bus.i_ls_we);
    rv_cycle = (state == WAIT) && (lat_cnt == 3'd1);
    denied   = (bus.i_if_req && !win_if) || (bus.i_ls_req && !win_ls);

    if (win_ls) begin
      bus.o_ls_gnt    = 1'b1;
      bus.o_mem_req   = 1'b1;
      bus.o_mem_we    = bus.i_ls_we;
      bus.o_mem_addr  = bus.i_ls_addr;
      bus.o_mem_wdata = bus.i_ls_wdata;
      bus.o_mem_bmask = bus.i_ls_we ? bus.i_ls_bmask : 4'b0000;
      last_gnt_nx     = OWN_LS;
    end else if (win_if) begin
      bus.o_if_gnt    = 1'b1;
      bus.o_mem_req   = 1'b1;
      bus.o_mem_addr  = bus.i_if_addr;
      last_gnt_nx     = OWN_IF;
    end

    if (rv_cycle) begin
      if (owner == OWN_LS) begin
        bus.o_ls_rvalid = 1'b1;
        bus.o_ls_rdata  = bus.i_mem_rdata;
      end else if (!drop && !bus.i_if_flush) begin
        bus.o_if_rvalid = 1'b1;
        bus.o_if_rdata  = bus.i_mem_rdata;
      end
    end

    if (state == WAIT) begin
      lat_nx = lat_cnt - 3'd1;
      if ((owner == OWN_IF) && bus.i_if_flush) drop_nx = 1'b1;
      if (lat_cnt == 3'd1) begin
        state_nx = IDLE;
        drop_nx  = 1'b0;
      end
    end

    // A read issued in the rvalid cycle overrides the return to IDLE.
    if (rd_issue) begin
      state_nx = WAIT;
      lat_nx   = 3'(MEM_LAT);
      owner_nx = win_ls ? OWN_LS : OWN_IF;
      drop_nx  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      conflict_cnt <= '0;
    end else if (denied && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  assign bus.o_busy         = (state == WAIT);
  assign bus.o_conflict_cnt = conflict_cnt;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter instances (MEM_LAT 1/2/3) share stimulus;
// each scenario checks the instance whose latency it targets.
module tb_mem_port_arbiter;
  logic        clk;
  logic        rst_n;
  logic        if_req, if_flush, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0]  ls_bmask;
  int unsigned n_checks;
  int unsigned n_errors;

  mem_port_arbiter_if #(.CNT_W(16)) b1 ();
  mem_port_arbiter_if #(.CNT_W(4))  b2 ();
  mem_port_arbiter_if #(.CNT_W(16)) b3 ();

  mem_port_arbiter #(.MEM_LAT(1), .CNT_W(16)) d1 (.i_clk(clk), .i_reset(rst_n), .bus(b1));
  mem_port_arbiter #(.MEM_LAT(2), .CNT_W(4))  d2 (.i_clk(clk), .i_reset(rst_n), .bus(b2));
  mem_port_arbiter #(.MEM_LAT(3), .CNT_W(16)) d3 (.i_clk(clk), .i_reset(rst_n), .bus(b3));

  assign b1.i_if_req = if_req;  assign b2.i_if_req = if_req;  assign b3.i_if_req = if_req;
  assign b1.i_if_addr = if_addr; assign b2.i_if_addr = if_addr; assign b3.i_if_addr = if_addr;
  assign b1.i_if_flush = if_flush; assign b2.i_if_flush = if_flush; assign b3.i_if_flush = if_flush;
  assign b1.i_ls_req = ls_req;  assign b2.i_ls_req = ls_req;  assign b3.i_ls_req = ls_req;
  assign b1.i_ls_we = ls_we;    assign b2.i_ls_we = ls_we;    assign b3.i_ls_we = ls_we;
  assign b1.i_ls_addr = ls_addr; assign b2.i_ls_addr = ls_addr; assign b3.i_ls_addr = ls_addr;
  assign b1.i_ls_wdata = ls_wdata; assign b2.i_ls_wdata = ls_wdata; assign b3.i_ls_wdata = ls_wdata;
  assign b1.i_ls_bmask = ls_bmask; assign b2.i_ls_bmask = ls_bmask; assign b3.i_ls_bmask = ls_bmask;
  assign b1.i_mem_rdata = mem_rdata; assign b2.i_mem_rdata = mem_rdata; assign b3.i_mem_rdata = mem_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req = 0; if_flush = 0; ls_req = 0; ls_we = 0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_bmask = '0; mem_rdata = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset state
    apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(b2.o_busy), 32'd0);
    check("rst_mem_req", 32'(b2.o_mem_req), 32'd0);
    check("rst_cnt", 32'(b2.o_conflict_cnt), 32'd0);
    rst_n = 1'b1;

    // Single fetch, MEM_LAT=2
    apply_reset();
    @(negedge clk); if_req = 1; if_addr = 32'h100; #1;
    check("a_if_gnt", 32'(b2.o_if_gnt), 32'd1);
    check("a_mem_addr", b2.o_mem_addr, 32'h100);
    check("a_mem_we", 32'(b2.o_mem_we), 32'd0);
    check("a_bmask", 32'(b2.o_mem_bmask), 32'd0);
    @(negedge clk); if_req = 0; #1;
    check("a_busy_t1", 32'(b2.o_busy), 32'd1);
    check("a_rv_t1", 32'(b2.o_if_rvalid), 32'd0);
    @(negedge clk); mem_rdata = 32'hCAFE0001; #1;
    check("a_rv_t2", 32'(b2.o_if_rvalid), 32'd1);
    check("a_rdata_t2", b2.o_if_rdata, 32'hCAFE0001);
    check("a_busy_t2", 32'(b2.o_busy), 32'd1);
    @(negedge clk); #1;
    check("a_busy_t3", 32'(b2.o_busy), 32'd0);
    check("a_rdata_t3", b2.o_if_rdata, 32'd0);

    // Tie after reset: store wins, fetch next cycle
    apply_reset();
    @(negedge clk);
    if_req = 1; if_addr = 32'h200;
    ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF; ls_bmask = 4'hF;
    #1;
    check("b_ls_gnt", 32'(b2.o_ls_gnt), 32'd1);
    check("b_if_gnt0", 32'(b2.o_if_gnt), 32'd0);
    check("b_mem_we", 32'(b2.o_mem_we), 32'd1);
    check("b_wdata", b2.o_mem_wdata, 32'hDEADBEEF);
    check("b_addr0", b2.o_mem_addr, 32'h2000);
    check("b_bmask0", 32'(b2.o_mem_bmask), 32'hF);
    @(negedge clk); ls_req = 0; ls_we = 0; #1;
    check("b_if_gnt1", 32'(b2.o_if_gnt), 32'd1);
    check("b_addr1", b2.o_mem_addr, 32'h200);
    check("b_bmask1", 32'(b2.o_mem_bmask), 32'd0);
    check("b_cnt", 32'(b2.o_conflict_cnt), 32'd1);
    @(negedge clk); if_req = 0; #1;
    check("b_busy", 32'(b2.o_busy), 32'd1);
    check("b_cnt_hold", 32'(b2.o_conflict_cnt), 32'd1);

    // Round-robin with back-to-back loads, MEM_LAT=1
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if_req = (i < 4); if_addr = 32'h300;
      ls_req = (i < 4); ls_we = 0; ls_addr = 32'h400;
      mem_rdata = 32'h1000 + 32'(i);
      #1;
      if (i < 4) begin
        check("c_ls_gnt", 32'(b1.o_ls_gnt), 32'(i % 2 == 0));
        check("c_if_gnt", 32'(b1.o_if_gnt), 32'(i % 2 == 1));
        check("c_mem_addr", b1.o_mem_addr, (i % 2 == 0) ? 32'h400 : 32'h300);
      end
      if (i > 0) begin
        check("c_ls_rv", 32'(b1.o_ls_rvalid), 32'(i % 2 == 1));
        check("c_if_rv", 32'(b1.o_if_rvalid), 32'(i % 2 == 0));
        check("c_rdata", (i % 2 == 1) ? b1.o_ls_rdata : b1.o_if_rdata, 32'h1000 + 32'(i));
      end
    end
    check("c_cnt", 32'(b1.o_conflict_cnt), 32'd4);

    // Flush of an outstanding fetch, MEM_LAT=3
    apply_reset();
    @(negedge clk); if_req = 1; if_addr = 32'h500; #1;
    check("d_gnt0", 32'(b3.o_if_gnt), 32'd1);
    @(negedge clk); if_req = 0; if_flush = 1; #1;
    @(negedge clk); if_flush = 0; #1;
    @(negedge clk); if_req = 1; if_addr = 32'h600; mem_rdata = 32'hBAD0BAD0; #1;
    check("d_no_rv", 32'(b3.o_if_rvalid), 32'd0);
    check("d_rdata0", b3.o_if_rdata, 32'd0);
    check("d_gnt3", 32'(b3.o_if_gnt), 32'd1);
    check("d_addr3", b3.o_mem_addr, 32'h600);
    @(negedge clk); if_req = 0; #1;
    check("d_busy4", 32'(b3.o_busy), 32'd1);
    @(negedge clk); #1;
    @(negedge clk); mem_rdata = 32'h600D0600; #1;
    check("d_rv6", 32'(b3.o_if_rvalid), 32'd1);
    check("d_rdata6", b3.o_if_rdata, 32'h600D0600);

    // Counter saturation, CNT_W=4
    apply_reset();
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if_req = 1; if_addr = 32'h700; ls_req = 1; ls_we = 0; ls_addr = 32'h800;
      #1;
      if (i == 14) check("e_cnt14", 32'(b2.o_conflict_cnt), 32'd14);
      if (i == 20) check("e_cnt_sat", 32'(b2.o_conflict_cnt), 32'hF);
      if (i == 21) check("e_cnt_hold", 32'(b2.o_conflict_cnt), 32'hF);
    end

    // Reset in the middle of a load, MEM_LAT=3
    apply_reset();
    @(negedge clk); ls_req = 1; ls_we = 0; ls_addr = 32'h900; #1;
    check("f_gnt", 32'(b3.o_ls_gnt), 32'd1);
    @(negedge clk); ls_req = 0; if_req = 1; if_addr = 32'hA00; #1;
    check("f_busy", 32'(b3.o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("f_rst_busy", 32'(b3.o_busy), 32'd0);
    check("f_rst_gnt", 32'(b3.o_if_gnt), 32'd0);
    check("f_rst_req", 32'(b3.o_mem_req), 32'd0);
    check("f_rst_addr", b3.o_mem_addr, 32'd0);
    @(negedge clk); if_req = 0; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_rdata = 32'h12345678; #1;
      check("f_no_rv", 32'(b3.o_ls_rvalid), 32'd0);
      check("f_idle", 32'(b3.o_busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
